// File: rtl/sel_scan_pkg.sv
// Shared types and sizes for the select-vector scan encoder.
// Optional macro SEL_SCAN_RR_EN (used by the top) selects round-robin priority.
package sel_scan_pkg;

  localparam int N = 16;
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, SCAN} state_t;
  typedef logic [N-1:0] vec_t;
  typedef logic [W-1:0] idx_t;

endpackage

// File: rtl/sel_first_set.sv
// Combinational search for the first set bit at or above ptr_i, wrapping N-1 -> 0.
// Also reports whether any bit is set and whether exactly one bit is set.
module sel_first_set
  import sel_scan_pkg::*;
(
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o,
  output logic         single_o
);

  idx_t off;

  // Walk offsets downward so the smallest offset from ptr_i wins.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[idx_t'(i) + ptr_i]) begin
        off = idx_t'(i);
      end
    end
  end

  assign idx_o    = off + ptr_i;
  assign any_o    = |vec_i;
  assign single_o = any_o && ((vec_i & (vec_i - vec_t'(1))) == '0);

endmodule

// File: rtl/sel_scan_encoder.sv
// Serialises a multi-hot select vector into one index per valid/ready handshake.
// Macro SEL_SCAN_RR_EN: round-robin start pointer persisting across vectors.
//
// state | meaning
// IDLE  | waiting for a vector; in_ready follows enable
// SCAN  | presenting pending set bits, one per handshake
module sel_scan_encoder
  import sel_scan_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [N-1:0] sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         empty
);

  state_t state_q, state_d;
  vec_t   pending_q, pending_d;
  logic   empty_q, empty_d;
  idx_t   ptr;
  idx_t   first_idx;
  logic   any_set;
  logic   single_set;

  sel_first_set u_first_set (
    .vec_i    (pending_q),
    .ptr_i    (ptr),
    .idx_o    (first_idx),
    .any_o    (any_set),
    .single_o (single_set)
  );

  assign in_ready  = (state_q == IDLE) && enable;
  assign out_valid = (state_q == SCAN) && any_set;
  assign in        = out_valid ? first_idx : '0;
  assign out_last  = out_valid && single_set;
  assign empty     = empty_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    empty_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          pending_d = sel;
          if (sel != '0) state_d = SCAN;
          else           empty_d = 1'b1;
        end
      end
      SCAN: begin
        if (out_valid && out_ready) begin
          pending_d[first_idx] = 1'b0;
          if (single_set) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      empty_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      empty_q   <= empty_d;
    end
  end

`ifdef SEL_SCAN_RR_EN
  idx_t ptr_q, ptr_d;

  // Next search starts just past the index that was consumed.
  always_comb begin
    ptr_d = ptr_q;
    if (out_valid && out_ready) ptr_d = first_idx + idx_t'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_sel_scan_encoder.sv
// Scoreboard bench for sel_scan_encoder: directed scenarios plus random traffic
// checked against a queue-based model of the expected index stream.
module tb_sel_scan_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sel;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        empty;

  sel_scan_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   log_q[$];
  bit   exp_empty = 1'b0;
  int   model_ptr = 0;
  int   checks    = 0;
  int   failures  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Expected stream for one accepted vector: repeatedly take the first set bit
  // searching upward from the pointer with wrap-around.
  function automatic void push_vec(input logic [15:0] v_in);
    logic [15:0] v;
    int p;
    int found;
    exp_t e;
    v = v_in;
    if (v == 16'h0) begin
      exp_empty = 1'b1;
      return;
    end
    p = model_ptr;
    while (v != 16'h0) begin
      found = 0;
      for (int j = 0; j < 16; j++) begin
        if (v[(p + j) % 16]) begin
          found = (p + j) % 16;
          break;
        end
      end
      v[found] = 1'b0;
      e.idx  = 4'(found);
      e.last = (v == 16'h0);
      exp_q.push_back(e);
`ifdef SEL_SCAN_RR_EN
      p = (found + 1) % 16;
`endif
    end
    model_ptr = p;
  endfunction

  always @(negedge clk) begin
    bit exp_ready;
    if (reset) begin
      chk("rst_in_ready", in_ready, enable);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in", in_idx, 4'h0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_empty", empty, 1'b0);
      exp_q.delete();
      exp_empty = 1'b0;
      model_ptr = 0;
    end else begin
      exp_ready = enable && (exp_q.size() == 0);
      chk("in_ready", in_ready, exp_ready);
      chk("empty", empty, exp_empty);
      exp_empty = 1'b0;
      if (out_valid && out_ready) log_q.push_back(int'(in_idx));
      if (exp_q.size() > 0) begin
        chk("out_valid", out_valid, 1'b1);
        chk("in", in_idx, exp_q[0].idx);
        chk("out_last", out_last, exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_valid_idle", out_valid, 1'b0);
        chk("in_idle", in_idx, 4'h0);
        chk("out_last_idle", out_last, 1'b0);
      end
      if (in_valid && exp_ready) push_vec(sel);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("idle_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    sel      = v;
    step();
    in_valid = 1'b0;
    sel      = 16'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  int exp6[4];

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    sel       = 16'h0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset in the middle of a stalled scan.
    out_ready = 1'b0;
    send(16'h00F0);
    step();
    step();
    enable = 1'b0;
    do_reset();
    enable    = 1'b1;
    out_ready = 1'b1;
    step();

    // Back-to-back emission.
    send(16'h8421);
    wait_idle();
    step();

    // Backpressure hold.
    out_ready = 1'b0;
    send(16'h0003);
    step();
    step();
    out_ready = 1'b1;
    wait_idle();
    step();

    // All-zero vector.
    send(16'h0000);
    step();
    step();

    // Refusal while disabled, then enable dropped mid-scan.
    enable   = 1'b0;
    in_valid = 1'b1;
    sel      = 16'h0001;
    step();
    step();
    step();
    in_valid  = 1'b0;
    enable    = 1'b1;
    out_ready = 1'b0;
    send(16'h0300);
    enable    = 1'b0;
    step();
    out_ready = 1'b1;
    wait_idle();
    step();
    enable = 1'b1;

    // Priority order across two vectors.
    do_reset();
    log_q.delete();
    send(16'h0011);
    wait_idle();
    send(16'h0021);
    wait_idle();
    step();
`ifdef SEL_SCAN_RR_EN
    exp6 = '{0, 4, 5, 0};
`else
    exp6 = '{0, 4, 0, 5};
`endif
    chk("t6_count", 32'(log_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) chk("t6_order", 32'(log_q[i]), 32'(exp6[i]));
    end

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      in_valid  = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       sel = 16'h0;
        1:       sel = 16'(1 << $urandom_range(0, 15));
        default: sel = 16'($urandom);
      endcase
      if (c == 300) begin
        in_valid = 1'b0;
        do_reset();
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    step();
    step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
